// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with selectable standard/first-word-fall-through read,
// almost-full/almost-empty thresholds, occupancy count and sticky error flags.
module sync_fifo_param #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 64,
    parameter int ADDR_WIDTH = 6,
    parameter int FWFT       = 0,
    parameter int AF_THRESH  = 60,
    parameter int AE_THRESH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [DATA_WIDTH-1:0] buf_in,
    input  logic                  clr_err,
    output logic [DATA_WIDTH-1:0] buf_out,
    output logic                  buf_full,
    output logic                  buf_empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   fifo_count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam logic [ADDR_WIDTH:0] FULL_CNT = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AF_CNT   = (ADDR_WIDTH+1)'(AF_THRESH);
    localparam logic [ADDR_WIDTH:0] AE_CNT   = (ADDR_WIDTH+1)'(AE_THRESH);
    localparam logic [ADDR_WIDTH:0] ONE_CNT  = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] ONE_PTR = ADDR_WIDTH'(1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic                  wr_acc;
    logic                  rd_acc;

    // Flags come only from the registered count, never from the request inputs.
    assign buf_full     = (fifo_count == FULL_CNT);
    assign buf_empty    = (fifo_count == '0);
    assign almost_full  = (fifo_count >= AF_CNT);
    assign almost_empty = (fifo_count <= AE_CNT);

    // A write into a full FIFO is allowed when a pop frees the slot on the same edge.
    assign wr_acc = wr_en && (!buf_full || rd_en);
    assign rd_acc = rd_en && !buf_empty;

    always_ff @(posedge clk) begin
        if (!rst && wr_acc) begin
            mem[wr_ptr] <= buf_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + ONE_PTR;
            if (rd_acc) rd_ptr <= rd_ptr + ONE_PTR;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fifo_count <= '0;
        end else begin
            case ({wr_acc, rd_acc})
                2'b10:   fifo_count <= fifo_count + ONE_CNT;
                2'b01:   fifo_count <= fifo_count - ONE_CNT;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Set has priority over clear so no error event is lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_en && buf_full && !rd_en) overflow <= 1'b1;
            else if (clr_err)                overflow <= 1'b0;
            if (rd_en && buf_empty)          underflow <= 1'b1;
            else if (clr_err)                underflow <= 1'b0;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign buf_out = mem[rd_ptr];
        end else begin : g_std
            always_ff @(posedge clk) begin
                if (rst)         buf_out <= '0;
                else if (rd_acc) buf_out <= mem[rd_ptr];
            end
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param: a standard-mode default instance and a small FWFT
// instance, both checked against queue-based reference models.
module tb_sync_fifo_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Standard-mode instance, default parameters
    logic       rst0 = 1'b1, wr0 = 1'b0, rd0 = 1'b0, clr0 = 1'b0;
    logic [7:0] din0 = '0, out0;
    logic       full0, empty0, af0, ae0, ovf0, udf0;
    logic [6:0] cnt0;

    sync_fifo_param dut0 (
        .clk(clk), .rst(rst0), .wr_en(wr0), .rd_en(rd0), .buf_in(din0), .clr_err(clr0),
        .buf_out(out0), .buf_full(full0), .buf_empty(empty0), .almost_full(af0),
        .almost_empty(ae0), .fifo_count(cnt0), .overflow(ovf0), .underflow(udf0)
    );

    // FWFT instance, DEPTH=16
    logic       rst1 = 1'b1, wr1 = 1'b0, rd1 = 1'b0, clr1 = 1'b0;
    logic [7:0] din1 = '0, out1;
    logic       full1, empty1, af1, ae1, ovf1, udf1;
    logic [4:0] cnt1;

    sync_fifo_param #(.DATA_WIDTH(8), .DEPTH(16), .ADDR_WIDTH(4), .FWFT(1),
                      .AF_THRESH(14), .AE_THRESH(2)) dut1 (
        .clk(clk), .rst(rst1), .wr_en(wr1), .rd_en(rd1), .buf_in(din1), .clr_err(clr1),
        .buf_out(out1), .buf_full(full1), .buf_empty(empty1), .almost_full(af1),
        .almost_empty(ae1), .fifo_count(cnt1), .overflow(ovf1), .underflow(udf1)
    );

    // Reference models: contents as a queue, plus sticky flags and last popped word.
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    bit         m_ovf0, m_udf0, m_ovf1, m_udf1;
    logic [7:0] m_out0;

    function automatic void m0_reset();
        q0.delete(); m_ovf0 = 0; m_udf0 = 0; m_out0 = 8'h00;
    endfunction

    function automatic void m1_reset();
        q1.delete(); m_ovf1 = 0; m_udf1 = 0;
    endfunction

    function automatic void m0_step(bit w, bit r, logic [7:0] d, bit c);
        bit full  = (q0.size() == 64);
        bit empty = (q0.size() == 0);
        if (r && !empty) m_out0 = q0.pop_front();
        if (w && (!full || r)) q0.push_back(d);
        if (w && full && !r) m_ovf0 = 1; else if (c) m_ovf0 = 0;
        if (r && empty) m_udf0 = 1; else if (c) m_udf0 = 0;
    endfunction

    function automatic void m1_step(bit w, bit r, logic [7:0] d, bit c);
        bit full  = (q1.size() == 16);
        bit empty = (q1.size() == 0);
        if (r && !empty) void'(q1.pop_front());
        if (w && (!full || r)) q1.push_back(d);
        if (w && full && !r) m_ovf1 = 1; else if (c) m_ovf1 = 0;
        if (r && empty) m_udf1 = 1; else if (c) m_udf1 = 0;
    endfunction

    // Drive one cycle, then sample #1 after the edge and advance the model.
    task automatic step0(input bit w, input bit r, input logic [7:0] d, input bit c);
        wr0 = w; rd0 = r; din0 = d; clr0 = c;
        @(posedge clk); #1;
        m0_step(w, r, d, c);
        wr0 = 0; rd0 = 0; clr0 = 0;
    endtask

    task automatic step1(input bit w, input bit r, input logic [7:0] d, input bit c);
        wr1 = w; rd1 = r; din1 = d; clr1 = c;
        @(posedge clk); #1;
        m1_step(w, r, d, c);
        wr1 = 0; rd1 = 0; clr1 = 0;
    endtask

    task automatic test_reset();
        rst0 = 1; wr0 = 1; rd0 = 1; din0 = 8'h3C;
        repeat (2) @(posedge clk);
        #1;
        rst0 = 0; wr0 = 0; rd0 = 0;
        m0_reset();
        checks++; if (cnt0 !== 7'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", cnt0); end
        checks++; if ({empty0, full0, ae0, af0} !== 4'b1010) begin errors++; $display("FAIL reset_flags: got e/f/ae/af=%b expected 1010", {empty0, full0, ae0, af0}); end
        checks++; if ({ovf0, udf0} !== 2'b00) begin errors++; $display("FAIL reset_err: got ovf/udf=%b expected 00", {ovf0, udf0}); end
        checks++; if (out0 !== 8'h00) begin errors++; $display("FAIL reset_out: got %h expected 00", out0); end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 64; i++) begin
            step0(1, 0, 8'($urandom), 0);
            checks++; if (int'(cnt0) !== q0.size()) begin errors++; $display("FAIL fill_count: got %0d expected %0d", cnt0, q0.size()); end
            checks++; if (af0 !== (q0.size() >= 60)) begin errors++; $display("FAIL fill_af: got %b at count %0d", af0, q0.size()); end
            checks++; if (full0 !== (q0.size() == 64)) begin errors++; $display("FAIL fill_full: got %b at count %0d", full0, q0.size()); end
        end
        step0(1, 0, 8'hEE, 0);
        checks++; if (ovf0 !== 1'b1) begin errors++; $display("FAIL overflow_set: got %b expected 1", ovf0); end
        checks++; if (cnt0 !== 7'd64) begin errors++; $display("FAIL overflow_count: got %0d expected 64", cnt0); end
        step0(0, 0, 8'h00, 1);
        checks++; if (ovf0 !== m_ovf0) begin errors++; $display("FAIL overflow_clr: got %b expected %b", ovf0, m_ovf0); end
    endtask

    task automatic test_drain();
        for (int i = 0; i < 64; i++) begin
            step0(0, 1, 8'h00, 0);
            checks++; if (out0 !== m_out0) begin errors++; $display("FAIL drain_data[%0d]: got %h expected %h", i, out0, m_out0); end
            checks++; if (ae0 !== (q0.size() <= 4) || empty0 !== (q0.size() == 0)) begin errors++; $display("FAIL drain_flags: got ae/e=%b%b at count %0d", ae0, empty0, q0.size()); end
        end
        step0(0, 1, 8'h00, 0);
        checks++; if (udf0 !== 1'b1) begin errors++; $display("FAIL underflow_set: got %b expected 1", udf0); end
        checks++; if (out0 !== m_out0) begin errors++; $display("FAIL underflow_hold: got %h expected %h", out0, m_out0); end
        step0(0, 0, 8'h00, 1);
    endtask

    task automatic test_edge();
        for (int i = 0; i < 64; i++) step0(1, 0, 8'($urandom), 0);
        // Overflow event together with clear: the set must win.
        step0(1, 0, 8'h11, 1);
        checks++; if (ovf0 !== 1'b1) begin errors++; $display("FAIL set_beats_clr: got %b expected 1", ovf0); end
        step0(1, 1, 8'h5A, 1);
        checks++; if (cnt0 !== 7'd64) begin errors++; $display("FAIL full_rw_count: got %0d expected 64", cnt0); end
        checks++; if (out0 !== m_out0) begin errors++; $display("FAIL full_rw_out: got %h expected %h", out0, m_out0); end
        for (int i = 0; i < 64; i++) begin
            step0(0, 1, 8'h00, 0);
            checks++; if (out0 !== m_out0) begin errors++; $display("FAIL full_rw_drain[%0d]: got %h expected %h", i, out0, m_out0); end
        end
        checks++; if (m_out0 !== 8'h5A) begin errors++; $display("FAIL full_rw_last: model last %h expected 5a", m_out0); end
        step0(1, 1, 8'h77, 0);
        checks++; if (cnt0 !== 7'd1) begin errors++; $display("FAIL empty_rw_count: got %0d expected 1", cnt0); end
        checks++; if (udf0 !== 1'b1) begin errors++; $display("FAIL empty_rw_udf: got %b expected 1", udf0); end
        step0(0, 1, 8'h00, 1);
        checks++; if (out0 !== 8'h77 || empty0 !== 1'b1) begin errors++; $display("FAIL empty_rw_data: got %h empty=%b expected 77 empty=1", out0, empty0); end
    endtask

    task automatic test_wrap();
        int bad = 0;
        rst0 = 1; @(posedge clk); #1; rst0 = 0; m0_reset();
        for (int i = 0; i < 10; i++) step0(1, 0, 8'($urandom), 0);
        for (int i = 0; i < 200; i++) begin
            step0(1, 1, 8'($urandom), 0);
            checks++; if (cnt0 !== 7'd10 || out0 !== m_out0) begin
                errors++; $display("FAIL wrap[%0d]: got count %0d out %h expected 10 %h", i, cnt0, out0, m_out0);
            end
        end
        checks++; if ({ovf0, udf0} !== {m_ovf0, m_udf0}) begin errors++; $display("FAIL wrap_err: got %b expected %b", {ovf0, udf0}, {m_ovf0, m_udf0}); end
        for (int i = 0; i < 10; i++) begin
            step0(0, 1, 8'h00, 0);
            if (out0 !== m_out0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL wrap_tail: got %0d bad words expected 0", bad); end
    endtask

    task automatic test_fwft();
        logic [7:0] w;
        rst1 = 1; @(posedge clk); #1; rst1 = 0; m1_reset();
        step1(1, 0, 8'hA5, 0);
        checks++; if (empty1 !== 1'b0 || out1 !== 8'hA5) begin errors++; $display("FAIL fwft_first: got empty=%b out=%h expected 0 a5", empty1, out1); end
        step1(0, 1, 8'h00, 0);
        checks++; if (empty1 !== 1'b1) begin errors++; $display("FAIL fwft_pop: got empty=%b expected 1", empty1); end
        for (int i = 0; i < 5; i++) step1(1, 0, 8'($urandom), 0);
        rst1 = 1; wr1 = 1; din1 = 8'hCC;
        @(posedge clk); #1;
        rst1 = 0; wr1 = 0; m1_reset();
        w = 8'($urandom);
        step1(1, 0, w, 0);
        checks++; if (out1 !== w || cnt1 !== 5'd1) begin errors++; $display("FAIL fwft_rst_burst: got out=%h count=%0d expected %h 1", out1, cnt1, w); end
        for (int i = 0; i < 300; i++) begin
            step1(($urandom % 3) != 0, ($urandom % 2) != 0, 8'($urandom), ($urandom % 8) == 0);
            checks++; if (int'(cnt1) !== q1.size() || full1 !== (q1.size() == 16) || empty1 !== (q1.size() == 0)
                          || af1 !== (q1.size() >= 14) || ae1 !== (q1.size() <= 2)) begin
                errors++; $display("FAIL fwft_rand_status[%0d]: got count %0d f/e/af/ae=%b%b%b%b expected count %0d", i, cnt1, full1, empty1, af1, ae1, q1.size());
            end
            checks++; if (q1.size() != 0 && out1 !== q1[0]) begin errors++; $display("FAIL fwft_rand_data[%0d]: got %h expected %h", i, out1, q1[0]); end
            checks++; if ({ovf1, udf1} !== {m_ovf1, m_udf1}) begin errors++; $display("FAIL fwft_rand_err[%0d]: got %b expected %b", i, {ovf1, udf1}, {m_ovf1, m_udf1}); end
        end
    endtask

    initial begin
        m0_reset();
        m1_reset();
        test_reset();
        test_fill();
        test_drain();
        test_edge();
        test_wrap();
        test_fwft();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
Single-clock, parametrised FIFO. It is the next-generation buffer for on-chip data paths that do not cross clock domains. It generalises width and depth and adds a selectable read mode (standard or first-word-fall-through), programmable almost-full and almost-empty thresholds, an occupancy count, and sticky overflow/underflow error flags. The port naming (buf_in/buf_out/buf_full/buf_empty) is kept, so existing benches and wrappers port over with minimal change.

Parameters:
DATA_WIDTH, 8, width of each data word in bits.
DEPTH, 64, number of entries; must be a power of 2 and at least 4.
ADDR_WIDTH, 6, log2(DEPTH); the pointer width.
FWFT, 0, read mode: 0 = standard (registered read), 1 = first-word-fall-through.
AF_THRESH, 60, almost_full asserts when occupancy is at least this value; range 1..DEPTH.
AE_THRESH, 4, almost_empty asserts when occupancy is at most this value; range 0..DEPTH-1.

Ports:
clk  in  1  single clock; all logic updates on the rising edge.
rst  in  1  synchronous, active-high reset.
wr_en  in  1  write request.
rd_en  in  1  read (pop) request.
buf_in  in  DATA_WIDTH  write data.
clr_err  in  1  clears the overflow and underflow flags.
buf_out  out  DATA_WIDTH  read data.
buf_full  out  1  occupancy == DEPTH.
buf_empty  out  1  occupancy == 0.
almost_full  out  1  occupancy >= AF_THRESH.
almost_empty  out  1  occupancy <= AE_THRESH.
fifo_count  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
overflow  out  1  sticky: a write was attempted while full and not accepted.
underflow  out  1  sticky: a read was attempted while empty.

Behaviour:
- Storage: DEPTH x DATA_WIDTH array. Pointers wr_ptr and rd_ptr are ADDR_WIDTH bits and wrap naturally from DEPTH-1 to 0. fifo_count is a registered counter.
- Reset: when rst=1 at a clk edge:
  - wr_ptr=0, rd_ptr=0, fifo_count=0;
  - buf_out=0 (standard mode);
  - overflow=0, underflow=0;
  - resulting flags: buf_empty=1, buf_full=0, almost_empty=1, almost_full=0 (given AF_THRESH>=1).
  - Memory contents are not reset.
  - Reset overrides every other input in the same cycle, including mid-operation; data in flight is discarded.
- Status flags are decoded from the registered fifo_count only, so they change on the same edge as the count. There are no combinational paths from wr_en or rd_en to any flag.
- Accepting requests:
  - write accepted = wr_en && (!buf_full || rd_en);
  - read accepted = rd_en && !buf_empty.
- Write: an accepted write stores buf_in at mem[wr_ptr], then wr_ptr increments.
- Read, standard mode (FWFT=0):
  - an accepted read loads buf_out <= mem[rd_ptr] and increments rd_ptr; read latency is 1 cycle;
  - buf_out holds its value when no read is accepted.
- Read, FWFT mode (FWFT=1):
  - buf_out = mem[rd_ptr] continuously; it is valid whenever buf_empty=0;
  - an accepted read advances rd_ptr and the next entry appears after the edge;
  - a word written into an empty FIFO is visible on buf_out one cycle after the write edge;
  - buf_out is don't-care while empty.
- Count update: +1 on write-only, -1 on read-only, unchanged when both or neither are accepted.
- Simultaneous read and write:
  - When full: both are accepted and count stays at DEPTH. In standard mode, buf_out receives the oldest entry.
  - When empty: the write is accepted, the read is rejected, underflow sets, and count becomes 1.
- Error flags:
  - wr_en && buf_full && !rd_en sets overflow;
  - rd_en && buf_empty sets underflow;
  - both flags hold until clr_err=1 or reset;
  - if a set event and clr_err occur in the same cycle, set wins.
- Rejected operations never modify the pointers, count, memory or buf_out.

Test Plan:
1. Reset: hold rst=1 for 2 edges during traffic -> fifo_count=0, buf_empty=1, buf_full=0, almost_empty=1, almost_full=0, overflow=0, underflow=0, buf_out=0.
2. Fill, FWFT=0, default parameters: write 64 random words with no reads -> almost_full rises on the edge where count reaches 60, buf_full rises at count=64. A 65th write sets overflow, count stays at 64, and stored data is unchanged. Then clr_err=1 -> overflow=0.
3. Drain, FWFT=0: apply 64 consecutive rd_en -> each word appears on buf_out 1 cycle after its rd_en, in write order. almost_empty rises at count=4, buf_empty=1 after the 64th read. A further rd_en sets underflow and buf_out holds its last value.
4. Edge cases: simultaneous wr_en and rd_en at count=64 -> count stays 64, the oldest word is output, and the new word is stored. Simultaneous wr_en and rd_en at count=0 -> count=1, underflow=1.
5. Wrap-around: preload 10 words, then drive 200 cycles of simultaneous read and write -> count is constant at 10, both pointers wrap at least 3 times, and the output sequence matches the reference queue exactly.
6. FWFT=1 with DEPTH=16, AF_THRESH=14, AE_THRESH=2: write 0xA5 into an empty FIFO -> on the next cycle buf_empty=0 and buf_out=0xA5 with no rd_en. Then one rd_en -> buf_empty=1 on the following cycle. Reset asserted mid-burst -> the next written word appears at buf_out.
